cv_layer_sched: RTL and testbench

//  Sequences one conv layer on the CV core by tiling over output- and input-channel chunks.
//  Per O-tile: load weights (+bias), then per I-tile load input (the core computes and accumulates

---
 rtl/cv_layer_sched.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_cv_layer_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_layer_sched.sv
// Sequences one conv layer on the CV core: per O-tile load weights, walk the I-tiles, then store output.
// Cmd pulses are registered; every request waits for core_idle, and every wait is covered by a watchdog.
module cv_layer_sched #(
    parameter int CW      = 11,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 60000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_I,
    input  logic [CW-1:0] cfg_O,
    input  logic [CW-1:0] cfg_IT,
    input  logic [CW-1:0] cfg_OT,
    input  logic [4:0]    cfg_K,
    input  logic [CW-1:0] cfg_H,
    input  logic [CW-1:0] cfg_W,
    input  logic          cfg_bias,
    input  logic          core_idle,
    output logic          load_weight,
    output logic          load_input,
    output logic          store_output,
    output logic [4:0]    K,
    output logic [CW-1:0] I,
    output logic [CW-1:0] Iori,
    output logic [CW-1:0] Iext,
    output logic [CW-1:0] Oext,
    output logic [CW-1:0] Hext,
    output logic [CW-1:0] Wext,
    output logic          has_bias,
    output logic [1:0]    phase,
    output logic [CW-1:0] tile_o,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_W_REQ, S_W_WAIT, S_I_REQ, S_I_WAIT,
        S_S_REQ, S_S_WAIT, S_NEXT_O, S_FIN
    } state_t;

    localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] LP_ONE     = TO_W'(1);

    function automatic logic [CW-1:0] f_min(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cfg_I, r_cfg_O, r_cfg_IT, r_cfg_OT, r_cfg_H, r_cfg_W;
    logic [4:0]    r_cfg_K;
    logic          r_cfg_bias;
    logic [CW-1:0] w_cfg_I_nxt, w_cfg_O_nxt, w_cfg_IT_nxt, w_cfg_OT_nxt, w_cfg_H_nxt, w_cfg_W_nxt;
    logic [4:0]    w_cfg_K_nxt;
    logic          w_cfg_bias_nxt;

    logic [4:0]    r_k, w_k_nxt;
    logic [CW-1:0] r_i, w_i_nxt;
    logic [CW-1:0] r_iori, w_iori_nxt, r_iext, w_iext_nxt;
    logic [CW-1:0] r_oori, w_oori_nxt, r_oext, w_oext_nxt;
    logic [CW-1:0] r_hext, w_hext_nxt, r_wext, w_wext_nxt;
    logic          r_has_bias, w_has_bias_nxt;

    logic          r_lw, w_lw_nxt, r_li, w_li_nxt, r_so, w_so_nxt;
    logic          r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
    logic          r_seen, w_seen_nxt;
    logic [TO_W-1:0] r_wd, w_wd_nxt;

    logic [CW-1:0] w_i_end, w_o_end, w_i_left, w_o_left;
    logic          w_cfg_bad, w_wait_exit, w_wait_abort;
    logic [1:0]    w_phase;

    assign w_i_end      = r_iori + r_iext;
    assign w_o_end      = r_oori + r_oext;
    assign w_i_left     = r_i - w_i_end;
    assign w_o_left     = r_cfg_O - w_o_end;
    assign w_cfg_bad    = (r_cfg_I == '0) || (r_cfg_O == '0) || (r_cfg_IT == '0) ||
                          (r_cfg_OT == '0) || (r_cfg_K == '0);
    // Exit needs an observed busy period, so the pulse cycle itself can never end a wait.
    assign w_wait_exit  = r_seen && core_idle;
    assign w_wait_abort = (r_wd == LP_TO_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_I_nxt    = r_cfg_I;
        w_cfg_O_nxt    = r_cfg_O;
        w_cfg_IT_nxt   = r_cfg_IT;
        w_cfg_OT_nxt   = r_cfg_OT;
        w_cfg_K_nxt    = r_cfg_K;
        w_cfg_H_nxt    = r_cfg_H;
        w_cfg_W_nxt    = r_cfg_W;
        w_cfg_bias_nxt = r_cfg_bias;
        w_k_nxt        = r_k;
        w_i_nxt        = r_i;
        w_iori_nxt     = r_iori;
        w_iext_nxt     = r_iext;
        w_oori_nxt     = r_oori;
        w_oext_nxt     = r_oext;
        w_hext_nxt     = r_hext;
        w_wext_nxt     = r_wext;
        w_has_bias_nxt = r_has_bias;
        w_busy_nxt     = r_busy;
        w_seen_nxt     = r_seen;
        w_wd_nxt       = r_wd;
        w_lw_nxt       = 1'b0;
        w_li_nxt       = 1'b0;
        w_so_nxt       = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        if (r_state == S_W_WAIT || r_state == S_I_WAIT || r_state == S_S_WAIT) begin
            w_seen_nxt = r_seen | ~core_idle;
            w_wd_nxt   = r_wd + LP_ONE;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cfg_I_nxt    = cfg_I;
                    w_cfg_O_nxt    = cfg_O;
                    w_cfg_IT_nxt   = cfg_IT;
                    w_cfg_OT_nxt   = cfg_OT;
                    w_cfg_K_nxt    = cfg_K;
                    w_cfg_H_nxt    = cfg_H;
                    w_cfg_W_nxt    = cfg_W;
                    w_cfg_bias_nxt = cfg_bias;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_CHK;
                end
            end
            S_CHK: begin
                if (w_cfg_bad) begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_k_nxt        = r_cfg_K;
                    w_i_nxt        = r_cfg_I;
                    w_hext_nxt     = r_cfg_H;
                    w_wext_nxt     = r_cfg_W;
                    w_has_bias_nxt = r_cfg_bias;
                    w_oori_nxt     = '0;
                    w_oext_nxt     = f_min(r_cfg_OT, r_cfg_O);
                    w_iori_nxt     = '0;
                    w_iext_nxt     = f_min(r_cfg_IT, r_cfg_I);
                    w_state_nxt    = S_W_REQ;
                end
            end
            S_W_REQ, S_I_REQ, S_S_REQ: begin
                if (core_idle) begin
                    w_seen_nxt = 1'b0;
                    w_wd_nxt   = '0;
                    case (r_state)
                        S_W_REQ: begin w_lw_nxt = 1'b1; w_state_nxt = S_W_WAIT; end
                        S_I_REQ: begin w_li_nxt = 1'b1; w_state_nxt = S_I_WAIT; end
                        default: begin w_so_nxt = 1'b1; w_state_nxt = S_S_WAIT; end
                    endcase
                end
            end
            S_W_WAIT, S_I_WAIT, S_S_WAIT: begin
                if (w_wait_exit) begin
                    case (r_state)
                        S_W_WAIT: w_state_nxt = S_I_REQ;
                        S_I_WAIT: begin
                            if (w_i_end == r_i) begin
                                w_state_nxt = S_S_REQ;
                            end else begin
                                w_iori_nxt  = w_i_end;
                                w_iext_nxt  = f_min(r_cfg_IT, w_i_left);
                                w_state_nxt = S_I_REQ;
                            end
                        end
                        default: w_state_nxt = S_NEXT_O;
                    endcase
                end else if (w_wait_abort) begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_NEXT_O: begin
                if (w_o_end == r_cfg_O) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_oori_nxt  = w_o_end;
                    w_oext_nxt  = f_min(r_cfg_OT, w_o_left);
                    w_iori_nxt  = '0;
                    w_iext_nxt  = f_min(r_cfg_IT, r_i);
                    w_state_nxt = S_W_REQ;
                end
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cfg_I    <= '0;
            r_cfg_O    <= '0;
            r_cfg_IT   <= '0;
            r_cfg_OT   <= '0;
            r_cfg_K    <= '0;
            r_cfg_H    <= '0;
            r_cfg_W    <= '0;
            r_cfg_bias <= 1'b0;
            r_k        <= '0;
            r_i        <= '0;
            r_iori     <= '0;
            r_iext     <= '0;
            r_oori     <= '0;
            r_oext     <= '0;
            r_hext     <= '0;
            r_wext     <= '0;
            r_has_bias <= 1'b0;
            r_lw       <= 1'b0;
            r_li       <= 1'b0;
            r_so       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_seen     <= 1'b0;
            r_wd       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cfg_I    <= w_cfg_I_nxt;
            r_cfg_O    <= w_cfg_O_nxt;
            r_cfg_IT   <= w_cfg_IT_nxt;
            r_cfg_OT   <= w_cfg_OT_nxt;
            r_cfg_K    <= w_cfg_K_nxt;
            r_cfg_H    <= w_cfg_H_nxt;
            r_cfg_W    <= w_cfg_W_nxt;
            r_cfg_bias <= w_cfg_bias_nxt;
            r_k        <= w_k_nxt;
            r_i        <= w_i_nxt;
            r_iori     <= w_iori_nxt;
            r_iext     <= w_iext_nxt;
            r_oori     <= w_oori_nxt;
            r_oext     <= w_oext_nxt;
            r_hext     <= w_hext_nxt;
            r_wext     <= w_wext_nxt;
            r_has_bias <= w_has_bias_nxt;
            r_lw       <= w_lw_nxt;
            r_li       <= w_li_nxt;
            r_so       <= w_so_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_seen     <= w_seen_nxt;
            r_wd       <= w_wd_nxt;
        end
    end

    always_comb begin
        w_phase = 2'd0;
        case (r_state)
            S_W_REQ, S_W_WAIT: w_phase = 2'd1;
            S_I_REQ, S_I_WAIT: w_phase = 2'd2;
            S_S_REQ, S_S_WAIT: w_phase = 2'd3;
            default:           w_phase = 2'd0;
        endcase
    end

    assign load_weight  = r_lw;
    assign load_input   = r_li;
    assign store_output = r_so;
    assign K            = r_k;
    assign I            = r_i;
    assign Iori         = r_iori;
    assign Iext         = r_iext;
    assign Oext         = r_oext;
    assign Hext         = r_hext;
    assign Wext         = r_wext;
    assign has_bias     = r_has_bias;
    assign phase        = w_phase;
    assign tile_o       = r_oori;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_cv_layer_sched.sv
// Directed bench for cv_layer_sched: a nested-loop tiling model predicts every cmd pulse and its geometry.
module tb_cv_layer_sched;
    localparam int CW  = 11;
    localparam int TO  = 300;
    localparam int BSY = 3;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [CW-1:0] cfg_I, cfg_O, cfg_IT, cfg_OT, cfg_H, cfg_W;
    logic [4:0]    cfg_K;
    logic          cfg_bias, core_idle;
    logic          load_weight, load_input, store_output, has_bias, busy, done, err;
    logic [4:0]    K;
    logic [CW-1:0] I, Iori, Iext, Oext, Hext, Wext, tile_o;
    logic [1:0]    phase;

    logic model_idle = 1'b1;
    logic hold_busy = 1'b0;
    logic ignore_input = 1'b0;
    assign core_idle = model_idle & ~hold_busy;

    cv_layer_sched #(.CW(CW), .TO_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_I(cfg_I), .cfg_O(cfg_O), .cfg_IT(cfg_IT), .cfg_OT(cfg_OT), .cfg_K(cfg_K),
        .cfg_H(cfg_H), .cfg_W(cfg_W), .cfg_bias(cfg_bias), .core_idle(core_idle),
        .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
        .K(K), .I(I), .Iori(Iori), .Iext(Iext), .Oext(Oext), .Hext(Hext), .Wext(Wext),
        .has_bias(has_bias), .phase(phase), .tile_o(tile_o), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    code;
        logic [CW-1:0] iori, iext, oori, oext;
    } exp_t;

    exp_t expq[$];
    int m_I, m_K, m_H, m_W;
    logic m_b;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, cnt_w = 0, cnt_i = 0, cnt_s = 0, cyc_li = 0;
    int rec_iext[$], rec_iori[$], rec_oext[$];
    int t2_iext[9] = '{4, 4, 2, 4, 4, 2, 4, 4, 2};
    int t2_iori[9] = '{0, 4, 8, 0, 4, 8, 0, 4, 8};
    int t2_oext[3] = '{2, 2, 1};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference tiling: plain nested loops over output and input channel chunks.
    task automatic build_model(input int ci, input int co, input int cit, input int cot);
        int oori, oext, iori, iext;
        exp_t e;
        oori = 0;
        while (oori < co) begin
            oext = (cot < co - oori) ? cot : co - oori;
            e.oori = CW'(oori); e.oext = CW'(oext);
            e.code = 2'd1; e.iori = '0; e.iext = CW'((cit < ci) ? cit : ci);
            expq.push_back(e);
            iori = 0; iext = 0;
            while (iori < ci) begin
                iext = (cit < ci - iori) ? cit : ci - iori;
                e.code = 2'd2; e.iori = CW'(iori); e.iext = CW'(iext);
                expq.push_back(e);
                iori += iext;
            end
            e.code = 2'd3; e.iori = CW'(iori - iext); e.iext = CW'(iext);
            expq.push_back(e);
            oori += oext;
        end
    endtask

    // Core stand-in: goes busy for BSY cycles after each cmd pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (load_weight || load_input || store_output) && !(load_input && ignore_input)) begin
                #1 model_idle = 1'b0;
                repeat (BSY) @(negedge clk);
                #1 model_idle = 1'b1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [71:0] geo_prev;
    logic geo_ok = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            geo_ok = 1'b0;
        end else begin
            int ncmd;
            exp_t e;
            logic [1:0] code;
            ncmd = int'(load_weight) + int'(load_input) + int'(store_output);
            if (ncmd > 1) chk("cmd_onehot", 128'(ncmd), 128'(1));
            if (ncmd == 1) begin
                code = load_weight ? 2'd1 : (load_input ? 2'd2 : 2'd3);
                if (expq.size() == 0) begin
                    chk("cmd_unexpected", 128'(code), 128'(0));
                end else begin
                    e = expq.pop_front();
                    chk("cmd_geom",
                        {code, Iori, Iext, tile_o, Oext, I, K, Hext, Wext, has_bias, phase, busy},
                        {e.code, e.iori, e.iext, e.oori, e.oext, CW'(m_I), 5'(m_K), CW'(m_H),
                         CW'(m_W), m_b, e.code, 1'b1});
                end
                if (load_weight) begin cnt_w++; rec_oext.push_back(int'(Oext)); end
                if (load_input) begin
                    cnt_i++; cyc_li = cyc;
                    rec_iext.push_back(int'(Iext)); rec_iori.push_back(int'(Iori));
                end
                if (store_output) cnt_s++;
            end
            if (done && prev_done) chk("done_width", 128'(2), 128'(1));
            if (err && prev_err) chk("err_width", 128'(2), 128'(1));
            if (geo_ok && (ncmd != 0 || !model_idle))
                chk("geom_stable", {K, I, Iori, Iext, Oext, Hext, Wext, has_bias}, geo_prev);
            geo_prev = {K, I, Iori, Iext, Oext, Hext, Wext, has_bias};
            geo_ok = 1'b1;
        end
        prev_done = done;
        prev_err = err;
    end

    task automatic check_all_zero(input string name);
        chk(name, {load_weight, load_input, store_output, K, I, Iori, Iext, Oext, Hext, Wext,
                   has_bias, phase, tile_o, busy, done, err}, '0);
    endtask

    task automatic do_start(input int ci, input int co, input int cit, input int cot,
                            input int ck, input int ch, input int cwd, input logic cb, input bit mdl);
        cfg_I = CW'(ci); cfg_O = CW'(co); cfg_IT = CW'(cit); cfg_OT = CW'(cot);
        cfg_K = 5'(ck); cfg_H = CW'(ch); cfg_W = CW'(cwd); cfg_bias = cb;
        if (mdl) begin
            m_I = ci; m_K = ck; m_H = ch; m_W = cwd; m_b = cb;
            build_model(ci, co, cit, cot);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int got);
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
            if (err) begin got = 2; break; end
        end
        if (got == 0) chk("end_timeout", 128'(0), 128'(1));
    endtask

    task automatic clear_rec();
        rec_iext.delete(); rec_iori.delete(); rec_oext.delete();
        cnt_w = 0; cnt_i = 0; cnt_s = 0;
    endtask

    initial begin
        int got;
        rst_n = 1'b0; start = 1'b0;
        cfg_I = '0; cfg_O = '0; cfg_IT = '0; cfg_OT = '0; cfg_K = '0; cfg_H = '0; cfg_W = '0;
        cfg_bias = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // 1) single tile
        clear_rec();
        do_start(4, 4, 4, 4, 3, 6, 6, 1'b1, 1'b1);
        wait_end(500, got);
        chk("t1_done", 128'(got), 128'(1));
        chk("t1_busy_low", 128'(busy), 128'(0));
        chk("t1_queue", 128'(expq.size()), 128'(0));
        chk("t1_counts", {32'(cnt_w), 32'(cnt_i), 32'(cnt_s)}, {32'd1, 32'd1, 32'd1});
        chk("t1_ext", {32'(rec_iext[0]), 32'(rec_iori[0]), 32'(rec_oext[0])}, {32'd4, 32'd0, 32'd4});
        @(negedge clk);
        chk("t1_done_pulse", 128'(done), 128'(0));

        // 2) partial tiles on both axes
        clear_rec();
        build_model(10, 5, 4, 2);
        chk("t2_model_len", 128'(expq.size()), 128'(15));
        expq.delete();
        do_start(10, 5, 4, 2, 5, 8, 9, 1'b0, 1'b1);
        wait_end(2000, got);
        chk("t2_done", 128'(got), 128'(1));
        chk("t2_queue", 128'(expq.size()), 128'(0));
        chk("t2_counts", {32'(cnt_w), 32'(cnt_i), 32'(cnt_s)}, {32'd3, 32'd9, 32'd3});
        if (rec_iext.size() == 9 && rec_oext.size() == 3) begin
            for (int k = 0; k < 9; k++) begin
                chk("t2_iext", 128'(rec_iext[k]), 128'(t2_iext[k]));
                chk("t2_iori", 128'(rec_iori[k]), 128'(t2_iori[k]));
            end
            for (int k = 0; k < 3; k++) chk("t2_oext", 128'(rec_oext[k]), 128'(t2_oext[k]));
        end else begin
            chk("t2_rec_len", 128'(rec_iext.size()), 128'(9));
        end

        // 3) zero tile size rejected
        clear_rec();
        do_start(4, 4, 0, 4, 3, 6, 6, 1'b0, 1'b0);
        chk("t3_in_chk", {busy, err}, {1'b1, 1'b0});
        @(negedge clk);
        chk("t3_err", {busy, err}, {1'b0, 1'b1});
        @(negedge clk);
        chk("t3_err_pulse", 128'(err), 128'(0));
        repeat (5) @(negedge clk);
        chk("t3_no_cmd", 128'(cnt_w + cnt_i + cnt_s), 128'(0));

        // 4) core never responds to load_input: watchdog abort
        clear_rec();
        ignore_input = 1'b1;
        do_start(4, 4, 4, 4, 3, 6, 6, 1'b0, 1'b1);
        wait_end(TO + 200, got);
        chk("t4_err", 128'(got), 128'(2));
        chk("t4_latency_ok", 128'((cyc - cyc_li) >= TO && (cyc - cyc_li) <= TO + 1), 128'(1));
        chk("t4_busy", {busy, phase}, {1'b0, 2'd0});
        repeat (20) @(negedge clk);
        chk("t4_no_cmd", {32'(cnt_w), 32'(cnt_i), 32'(cnt_s)}, {32'd1, 32'd1, 32'd0});
        ignore_input = 1'b0;
        expq.delete();

        // 5) async reset during second I-tile wait, then full rerun
        clear_rec();
        do_start(10, 5, 4, 2, 5, 8, 9, 1'b1, 1'b1);
        for (int k = 0; k < 500; k++) begin
            if (cnt_i >= 2) break;
            @(negedge clk);
        end
        chk("t5_reached_tile2", 128'(cnt_i), 128'(2));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        for (int k = 0; k < 20 && !model_idle; k++) @(negedge clk);
        @(negedge clk);
        clear_rec();
        do_start(10, 5, 4, 2, 5, 8, 9, 1'b1, 1'b1);
        wait_end(2000, got);
        chk("t5_rerun_done", 128'(got), 128'(1));
        chk("t5_rerun_counts", {32'(cnt_w), 32'(cnt_i), 32'(cnt_s), 32'(expq.size())},
            {32'd3, 32'd9, 32'd3, 32'd0});

        // 6) core busy at W_REQ, plus a start while busy
        clear_rec();
        hold_busy = 1'b1;
        do_start(6, 3, 4, 2, 3, 5, 5, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        chk("t6_lw_held", {32'(cnt_w), 30'd0, phase, busy}, {32'd0, 30'd0, 2'd1, 1'b1});
        do_start(1, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
        @(negedge clk);
        hold_busy = 1'b0;
        wait_end(2000, got);
        chk("t6_done", 128'(got), 128'(1));
        chk("t6_counts", {32'(cnt_w), 32'(cnt_i), 32'(cnt_s), 32'(expq.size())},
            {32'd2, 32'd4, 32'd2, 32'd0});

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
